// File: rtl/debug_frame_sched_pkg.sv
// debug_frame_sched_pkg
//   Shared definitions for the debug-variable display scheduler: FSM state
//   encodings and the default sequence count/width that pixel_gen and the pad
//   logic also use.
//   No ports (package).
package debug_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  localparam int DBG_SEQ_NUM = 17;
  localparam int DBG_SEQ_LEN = 16;

endpackage

// File: rtl/debug_frame_sched_snap_bank.sv
// debug_frame_sched_snap_bank
//   SEQ_NUM x SEQ_LEN snapshot bank. All entries are captured together on
//   'capture'; one entry is read back through an indexed mux.
//   With DEBUG_SCHED_SKIP_EN defined it also holds the prev[] bank (value last
//   handed to the converter per slot) and compares cmp_data against prev[rd_idx].
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   capture        load every entry from seq_in
//   seq_in         flattened sequences, entry i = seq_in[i*SEQ_LEN +: SEQ_LEN]
//   rd_idx/rd_data indexed read of the snapshot (0 for an out-of-range index)
//   prev_we/prev_idx/prev_data   prev[] write port        (DEBUG_SCHED_SKIP_EN)
//   cmp_data/cmp_match           cmp_data == prev[rd_idx] (DEBUG_SCHED_SKIP_EN)
module debug_frame_sched_snap_bank
  import debug_frame_sched_pkg::*;
#(
  parameter int SEQ_NUM = DBG_SEQ_NUM,
  parameter int SEQ_LEN = DBG_SEQ_LEN,
  parameter int IDX_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture,
  input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [SEQ_LEN-1:0]         rd_data
`ifdef DEBUG_SCHED_SKIP_EN
  ,
  input  logic                       prev_we,
  input  logic [IDX_W-1:0]           prev_idx,
  input  logic [SEQ_LEN-1:0]         prev_data,
  input  logic [SEQ_LEN-1:0]         cmp_data,
  output logic                       cmp_match
`endif
);

  logic [SEQ_LEN-1:0] snap_r [SEQ_NUM];

  // Snapshot capture: every slot loads at once so a pass sees one coherent frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_NUM; i++) snap_r[i] <= {SEQ_LEN{1'b0}};
    end else if (capture) begin
      for (int i = 0; i < SEQ_NUM; i++) snap_r[i] <= seq_in[i*SEQ_LEN +: SEQ_LEN];
    end
  end

  // Indexed read mux; the index may run one past the last slot and then reads 0.
  always_comb begin
    rd_data = {SEQ_LEN{1'b0}};
    for (int i = 0; i < SEQ_NUM; i++) begin
      rd_data = (rd_idx == IDX_W'(i)) ? snap_r[i] : rd_data;
    end
  end

`ifdef DEBUG_SCHED_SKIP_EN
  logic [SEQ_LEN-1:0] prev_r [SEQ_NUM];
  logic [SEQ_LEN-1:0] prev_rd_s;

  // prev[] bank: remembers the value last accepted by the converter per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_NUM; i++) prev_r[i] <= {SEQ_LEN{1'b0}};
    end else begin
      for (int i = 0; i < SEQ_NUM; i++) begin
        if (prev_we && (prev_idx == IDX_W'(i))) prev_r[i] <= prev_data;
      end
    end
  end

  // Unchanged-entry comparator at the read index.
  always_comb begin
    prev_rd_s = {SEQ_LEN{1'b0}};
    for (int i = 0; i < SEQ_NUM; i++) begin
      prev_rd_s = (rd_idx == IDX_W'(i)) ? prev_r[i] : prev_rd_s;
    end
    cmp_match = (prev_rd_s == cmp_data);
  end
`endif

endmodule

// File: rtl/debug_frame_sched.sv
// debug_frame_sched
//   Frame-synchronous scheduler for the debug-variable display. On frame_start
//   (not frozen, idle) all sequences are snapshotted and then offered one at a
//   time to a single shared sequence-to-font converter over a req/ack handshake.
//   Optional feature macro: DEBUG_SCHED_SKIP_EN -- skip entries whose value
//   matches what the converter already holds (after the first pass).
// Ports
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   frame_start         1-cycle vsync pulse, requests a pass
//   freeze              hold the current display (frame_start ignored in idle)
//   seq_in              flattened sequences, entry i = seq_in[i*SEQ_LEN +: SEQ_LEN]
//   conv_req/conv_idx/conv_data  converter request, slot index and snapshot value
//   conv_ack            converter accepted the current entry
//   busy                pass in progress (REQ or DONE)
//   frame_done          1-cycle pulse after the last entry of a pass
//   overrun_cnt         saturating count of frame_start pulses dropped while busy
module debug_frame_sched
  import debug_frame_sched_pkg::*;
#(
  parameter int SEQ_NUM = DBG_SEQ_NUM,
  parameter int SEQ_LEN = DBG_SEQ_LEN,
  parameter int IDX_W   = 5,
  parameter int OVR_W   = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       frame_start,
  input  logic                       freeze,
  input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in,
  output logic                       conv_req,
  output logic [IDX_W-1:0]           conv_idx,
  output logic [SEQ_LEN-1:0]         conv_data,
  input  logic                       conv_ack,
  output logic                       busy,
  output logic                       frame_done,
  output logic [OVR_W-1:0]           overrun_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_NUM - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = {OVR_W{1'b1}};

  sched_state_e       state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               conv_req_r;
  logic [SEQ_LEN-1:0] conv_data_r;
  logic               busy_r;
  logic               frame_done_r;
  logic [OVR_W-1:0]   overrun_cnt_r;

  logic               capture_s;
  logic               step_s;
  logic               last_s;
  logic               pass_end_s;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [SEQ_LEN-1:0] rd_data_s;
  logic [SEQ_LEN-1:0] load_data_s;
  logic               skip_s;

  assign capture_s = (state_r == ST_IDLE) && frame_start && !freeze;
  // A REQ cycle moves on when the entry is acked, or unconditionally when the
  // current slot was skipped (conv_req low inside REQ).
  assign step_s     = (state_r == ST_REQ) && (conv_ack || !conv_req_r);
  assign last_s     = (idx_r == LAST_IDX);
  assign pass_end_s = step_s && last_s;
  assign nxt_idx_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

  // Select the slot being loaded next: slot 0 comes straight from seq_in on
  // capture because the bank only holds it from the following cycle.
  always_comb begin
    if (state_r == ST_IDLE) begin
      rd_idx_s    = {IDX_W{1'b0}};
      load_data_s = seq_in[SEQ_LEN-1:0];
    end else begin
      rd_idx_s    = nxt_idx_s;
      load_data_s = rd_data_s;
    end
  end

`ifdef DEBUG_SCHED_SKIP_EN
  logic first_pass_r;
  logic cmp_match_s;
  logic prev_we_s;

  assign prev_we_s = (state_r == ST_REQ) && conv_req_r && conv_ack;
  assign skip_s    = cmp_match_s && !first_pass_r;

  // first_pass: nothing can be skipped until one full pass has filled prev[].
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      first_pass_r <= 1'b1;
    end else if (pass_end_s) begin
      first_pass_r <= 1'b0;
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  debug_frame_sched_snap_bank #(
    .SEQ_NUM (SEQ_NUM),
    .SEQ_LEN (SEQ_LEN),
    .IDX_W   (IDX_W)
  ) u_snap_bank (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .capture   (capture_s),
    .seq_in    (seq_in),
    .rd_idx    (rd_idx_s),
    .rd_data   (rd_data_s)
`ifdef DEBUG_SCHED_SKIP_EN
    ,
    .prev_we   (prev_we_s),
    .prev_idx  (idx_r),
    .prev_data (conv_data_r),
    .cmp_data  (load_data_s),
    .cmp_match (cmp_match_s)
`endif
  );

  // Scheduler FSM, index counter, overrun counter and all registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= {IDX_W{1'b0}};
      conv_req_r    <= 1'b0;
      conv_data_r   <= {SEQ_LEN{1'b0}};
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      overrun_cnt_r <= {OVR_W{1'b0}};
    end else begin
      frame_done_r <= 1'b0;
      if (frame_start && (state_r != ST_IDLE) && (overrun_cnt_r != OVR_MAX)) begin
        overrun_cnt_r <= overrun_cnt_r + {{(OVR_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            state_r     <= ST_REQ;
            idx_r       <= {IDX_W{1'b0}};
            busy_r      <= 1'b1;
            conv_req_r  <= !skip_s;
            conv_data_r <= load_data_s;
          end
        end
        ST_REQ: begin
          if (pass_end_s) begin
            state_r      <= ST_DONE;
            conv_req_r   <= 1'b0;
            frame_done_r <= 1'b1;
          end else if (step_s) begin
            idx_r       <= nxt_idx_s;
            conv_req_r  <= !skip_s;
            conv_data_r <= load_data_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          conv_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign conv_req    = conv_req_r;
  assign conv_idx    = idx_r;
  assign conv_data   = conv_data_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign overrun_cnt = overrun_cnt_r;

endmodule

// File: tb/tb_debug_frame_sched.sv
// Testbench for debug_frame_sched (SEQ_NUM=4, SEQ_LEN=16, IDX_W=2, OVR_W=8).
// A pass is modelled as a queue of slots (index + requested flag) built at the
// frame_start that captures the snapshot; each cycle the head slot is offered
// and popped when acked (or at once if skipped). Checks every cycle against it.
module tb_debug_frame_sched;

  localparam int SEQ_NUM = 4;
  localparam int SEQ_LEN = 16;
  localparam int IDX_W   = 2;
  localparam int OVR_W   = 8;
`ifdef DEBUG_SCHED_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                       sys_clk = 1'b0;
  logic                       sys_rst_n;
  logic                       frame_start;
  logic                       freeze;
  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in;
  logic                       conv_req;
  logic [IDX_W-1:0]           conv_idx;
  logic [SEQ_LEN-1:0]         conv_data;
  logic                       conv_ack;
  logic                       busy;
  logic                       frame_done;
  logic [OVR_W-1:0]           overrun_cnt;

  always #5 sys_clk = ~sys_clk;

  debug_frame_sched #(
    .SEQ_NUM (SEQ_NUM),
    .SEQ_LEN (SEQ_LEN),
    .IDX_W   (IDX_W),
    .OVR_W   (OVR_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_start (frame_start),
    .freeze      (freeze),
    .seq_in      (seq_in),
    .conv_req    (conv_req),
    .conv_idx    (conv_idx),
    .conv_data   (conv_data),
    .conv_ack    (conv_ack),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; bit req; } slot_t;
  slot_t       m_q[$];
  int          m_phase;          // 0 idle, 1 pass running, 2 done cycle
  logic [15:0] m_snap [SEQ_NUM];
  logic [15:0] m_prev [SEQ_NUM];
  bit          m_first;
  int          m_ovr;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_first = 1'b1;
    m_ovr   = 0;
    for (int i = 0; i < SEQ_NUM; i++) begin
      m_snap[i] = 16'h0000;
      m_prev[i] = 16'h0000;
    end
  endtask

  task automatic model_edge();
    slot_t s;
    if (m_phase != 0 && frame_start && m_ovr < 255) m_ovr++;
    case (m_phase)
      0: if (frame_start && !freeze) begin
        for (int i = 0; i < SEQ_NUM; i++) begin
          m_snap[i] = seq_in[i*SEQ_LEN +: SEQ_LEN];
          s.idx = i;
          s.req = !(SKIP && !m_first && (m_snap[i] == m_prev[i]));
          m_q.push_back(s);
        end
        m_phase = 1;
      end
      1: if (!m_q[0].req || conv_ack) begin
        if (m_q[0].req) m_prev[m_q[0].idx] = m_snap[m_q[0].idx];
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_phase = 2;
          m_first = 1'b0;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    bit e_req;
    e_req = (m_phase == 1) && m_q[0].req;
    chk("conv_req", 32'(conv_req), 32'(e_req));
    if (e_req) begin
      chk("conv_idx", 32'(conv_idx), 32'(m_q[0].idx));
      chk("conv_data", 32'(conv_data), 32'(m_snap[m_q[0].idx]));
    end
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("frame_done", 32'(frame_done), 32'(m_phase == 2));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
  endtask

  task automatic step(input bit fs, input bit fz, input bit ack);
    @(negedge sys_clk);
    frame_start = fs;
    freeze      = fz;
    conv_ack    = ack;
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit fs; bit fz; bit ack;
    bit e_req; int e_idx; logic [15:0] e_data; bit e_busy; bit e_fd;
  } vec_t;
  vec_t vt[8];

  initial begin
    int nreq;
    int last_idx;
    int nfd;
    logic [15:0] held;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 16'h000A, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 16'h000B, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 16'h000C, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 16'h000D, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0};

    sys_rst_n   = 1'b0;
    frame_start = 1'b0;
    freeze      = 1'b0;
    conv_ack    = 1'b0;
    seq_in      = 64'h000D_000C_000B_000A;
    model_reset();
    repeat (2) @(negedge sys_clk);
    chk("rst_req", 32'(conv_req), 32'd0);
    chk("rst_idx", 32'(conv_idx), 32'd0);
    chk("rst_data", 32'(conv_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    sys_rst_n = 1'b1;

    // Test 1 + freeze (test 4): table-driven
    for (int k = 0; k < 8; k++) begin
      step(vt[k].fs, vt[k].fz, vt[k].ack);
      chk("tbl_req", 32'(conv_req), 32'(vt[k].e_req));
      if (vt[k].e_req) begin
        chk("tbl_idx", 32'(conv_idx), 32'(vt[k].e_idx));
        chk("tbl_data", 32'(conv_data), 32'(vt[k].e_data));
      end
      chk("tbl_busy", 32'(busy), 32'(vt[k].e_busy));
      chk("tbl_fd", 32'(frame_done), 32'(vt[k].e_fd));
      chk("tbl_ovr", 32'(overrun_cnt), 32'd0);
    end

    // Test 2: ack withheld at idx 2 for 10 cycles, seq_in churns meanwhile
    seq_in = 64'h4444_3333_2222_1111;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    held = conv_data;
    chk("hold_first_data", 32'(held), 32'h3333);
    for (int k = 0; k < 10; k++) begin
      seq_in = {$urandom(), $urandom()};
      step(1'b0, 1'b0, 1'b0);
      chk("hold_req", 32'(conv_req), 32'd1);
      chk("hold_idx", 32'(conv_idx), 32'd2);
      chk("hold_data", 32'(conv_data), 32'h3333);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("after_hold_data", 32'(conv_data), 32'h4444);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Test 3: overrun counting and saturation
    seq_in = 64'h5555_6666_7777_8888;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("ovr_three", 32'(overrun_cnt), 32'd3);
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("ovr_sat_idle", 32'(busy), 32'd0);

    // Test 5: asynchronous reset mid-pass at idx 1
    seq_in = 64'h0104_0103_0102_0101;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("pre_rst_idx", 32'(conv_idx), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(conv_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    chk("arst_ovr", 32'(overrun_cnt), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    chk("restart_req", 32'(conv_req), 32'd1);
    chk("restart_idx", 32'(conv_idx), 32'd0);
    repeat (6) step(1'b0, 1'b0, 1'b1);

    // Test 6: second pass with only entry 3 changed
    seq_in = 64'h0AA4_0AA3_0AA2_0AA1;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      step(k == 0, 1'b0, 1'b1);
      if (conv_req) nreq++;
    end
    chk("pass1_nreq", 32'(nreq), 32'd4);
    seq_in[63:48] = 16'h0BB4;
    nreq = 0; nfd = 0; last_idx = -1;
    for (int k = 0; k < 8; k++) begin
      step(k == 0, 1'b0, 1'b1);
      if (conv_req) begin
        nreq++;
        last_idx = int'(conv_idx);
      end
      if (frame_done) nfd++;
    end
    chk("pass2_nreq", 32'(nreq), SKIP ? 32'd1 : 32'd4);
    chk("pass2_last_idx", 32'(last_idx), 32'd3);
    chk("pass2_fd", 32'(nfd), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < SEQ_NUM; i++) seq_in[i*SEQ_LEN +: SEQ_LEN] = 16'($urandom_range(0, 3));
      end
      step($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
